// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multi-cycle RV32I subset (lw, sw, R/I-ALU, beq, jal).
// Sequences the shared ALU, register file, IR and unified memory port across cycles.
module multicycle_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       AdrSrc,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic [1:0] ImmSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [2:0] ALUControl,
  output logic       illegal,
  output logic [3:0] state
);

  localparam int unsigned StateW = 4;

  localparam logic [6:0] OpLw   = 7'b0000011;
  localparam logic [6:0] OpSw   = 7'b0100011;
  localparam logic [6:0] OpR    = 7'b0110011;
  localparam logic [6:0] OpI    = 7'b0010011;
  localparam logic [6:0] OpBeq  = 7'b1100011;
  localparam logic [6:0] OpJal  = 7'b1101111;

  localparam logic [2:0] AluAdd = 3'b000;
  localparam logic [2:0] AluSub = 3'b001;
  localparam logic [2:0] AluAnd = 3'b010;
  localparam logic [2:0] AluOr  = 3'b011;
  localparam logic [2:0] AluSlt = 3'b101;

  typedef enum logic [StateW-1:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_ILLEGAL  = 4'd11
  } state_t;

  state_t     state_q, state_d;
  logic       illegal_q;
  logic [2:0] alu_dec;
  logic       req_s, irw_s, pcw_s, rgw_s, mw_s;

  // State register and sticky illegal flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_q | (state_d == S_ILLEGAL);
    end
  end

  // ALU operation for register/immediate arithmetic
  always_comb begin
    alu_dec = AluAdd;
    case (funct3)
      3'b000:  alu_dec = (funct7b5 & op[5]) ? AluSub : AluAdd;
      3'b010:  alu_dec = AluSlt;
      3'b110:  alu_dec = AluOr;
      3'b111:  alu_dec = AluAnd;
      default: alu_dec = AluAdd;
    endcase
  end

  // Immediate format follows the latched opcode in every state
  always_comb begin
    ImmSrc = 2'b00;
    case (op)
      OpSw:    ImmSrc = 2'b01;
      OpBeq:   ImmSrc = 2'b10;
      OpJal:   ImmSrc = 2'b11;
      default: ImmSrc = 2'b00;
    endcase
  end

  // Next-state and datapath control
  always_comb begin
    state_d    = state_q;
    req_s      = 1'b0;
    AdrSrc     = 1'b0;
    irw_s      = 1'b0;
    pcw_s      = 1'b0;
    rgw_s      = 1'b0;
    mw_s       = 1'b0;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ResultSrc  = 2'b00;
    ALUControl = AluAdd;
    case (state_q)
      S_FETCH: begin
        req_s     = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        irw_s     = mem_ready;
        pcw_s     = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (op)
          OpLw, OpSw: state_d = S_MEMADR;
          OpR:        state_d = S_EXECR;
          OpI:        state_d = S_EXECI;
          OpBeq:      state_d = S_BEQ;
          OpJal:      state_d = S_JAL;
          default:    state_d = S_ILLEGAL;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        state_d = op[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        req_s  = 1'b1;
        AdrSrc = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        rgw_s     = 1'b1;
        state_d   = S_FETCH;
      end
      S_MEMWRITE: begin
        req_s  = 1'b1;
        mw_s   = 1'b1;
        AdrSrc = 1'b1;
        if (mem_ready) state_d = S_FETCH;
      end
      S_EXECR: begin
        ALUSrcA    = 2'b10;
        ALUControl = alu_dec;
        state_d    = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        ALUControl = alu_dec;
        state_d    = S_ALUWB;
      end
      S_ALUWB: begin
        rgw_s   = 1'b1;
        state_d = S_FETCH;
      end
      S_BEQ: begin
        ALUSrcA    = 2'b10;
        ALUControl = AluSub;
        pcw_s      = zero;
        state_d    = S_FETCH;
      end
      S_JAL: begin
        // PC loads the target already in ALUOut while the ALU forms OldPC+4 for rd
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        pcw_s   = 1'b1;
        state_d = S_ALUWB;
      end
      S_ILLEGAL: state_d = S_ILLEGAL;
      default:   state_d = S_ILLEGAL;
    endcase
  end

  // Strobes are held low asynchronously while reset is asserted
  assign mem_req  = rst_n & req_s;
  assign IRWrite  = rst_n & irw_s;
  assign PCWrite  = rst_n & pcw_s;
  assign RegWrite = rst_n & rgw_s;
  assign MemWrite = rst_n & mw_s;
  assign illegal  = illegal_q;
  assign state    = state_q;

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Main control FSM for the multi-cycle RV32I core subset: lw, sw, R-type ALU, I-type ALU, beq, jal. It sequences the shared ALU, register file, instruction register and unified memory port across cycles. It also drives `ImmSrc` to the sign-extend unit from the latched opcode. It sits between the instruction register and the datapath muxes and handshakes with the memory interface via `mem_req`/`mem_ready`.

## Interface
- No parameters.

Ports:
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous active-low reset
- `op`  in  7  opcode from instruction register
- `funct3`  in  3  instr[14:12]
- `funct7b5`  in  1  instr[30]
- `zero`  in  1  ALU zero flag
- `mem_ready`  in  1  memory completes the current access this cycle
- `mem_req`  out  1  memory access request
- `AdrSrc`  out  1  address mux: 0 = PC, 1 = ALUOut
- `IRWrite`  out  1  instruction register load
- `PCWrite`  out  1  PC load
- `RegWrite`  out  1  register file write
- `MemWrite`  out  1  store strobe, qualifies `mem_req`
- `ImmSrc`  out  2  immediate format: 00 I, 01 S, 10 B, 11 J
- `ALUSrcA`  out  2  00 PC, 01 OldPC, 10 rd1
- `ALUSrcB`  out  2  00 rd2, 01 ImmExt, 10 constant 4
- `ResultSrc`  out  2  00 ALUOut, 01 Data, 10 ALUResult
- `ALUControl`  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- `illegal`  out  1  sticky unsupported-opcode flag
- `state`  out  4  current state, for debug and verification

## Operation
State encoding: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECR 6, EXECI 7, ALUWB 8, BEQ 9, JAL 10, ILLEGAL 11.

All outputs default to 0 unless a state sets them.

- **FETCH:** `mem_req`=1, `AdrSrc`=0, `ALUSrcA`=00, `ALUSrcB`=10, add, `ResultSrc`=10.
  - `IRWrite`=`PCWrite`=`mem_ready`.
  - Stay while `mem_ready`=0; go to DECODE when `mem_ready`=1.
- **DECODE:** `ALUSrcA`=01, `ALUSrcB`=01, add. This computes the branch/jump target into ALUOut.
  - Next state by `op`: 0000011 or 0100011 → MEMADR; 0110011 → EXECR; 0010011 → EXECI; 1100011 → BEQ; 1101111 → JAL; any other → ILLEGAL.
- **MEMADR:** `ALUSrcA`=10, `ALUSrcB`=01, add. `op[5]`=0 → MEMREAD; `op[5]`=1 → MEMWRITE.
- **MEMREAD:** `mem_req`=1, `AdrSrc`=1. Wait for `mem_ready`, then → MEMWB.
- **MEMWB:** `ResultSrc`=01, `RegWrite`=1 → FETCH.
- **MEMWRITE:** `mem_req`=1, `MemWrite`=1, `AdrSrc`=1. Wait for `mem_ready`, then → FETCH.
- **EXECR / EXECI:** `ALUSrcA`=10, `ALUSrcB`=00 (EXECR) or 01 (EXECI), ALU op decoded from funct fields → ALUWB.
- **ALUWB:** `ResultSrc`=00, `RegWrite`=1 → FETCH.
- **BEQ:** `ALUSrcA`=10, `ALUSrcB`=00, sub, `ResultSrc`=00, `PCWrite`=`zero` → FETCH.
- **JAL:** `ALUSrcA`=01, `ALUSrcB`=10, add, `ResultSrc`=00, `PCWrite`=1 → ALUWB. PC takes the target held in ALUOut; rd gets OldPC+4.
- **ILLEGAL:** all strobes 0, `illegal`=1. The state is held until reset.

ALU decode (EXECR/EXECI only):
- funct3 000 → sub if `funct7b5 & op[5]`, else add.
- funct3 010 → slt.
- funct3 110 → or.
- funct3 111 → and.
- Other funct3 → add.

`ImmSrc` is combinational from `op` in every state: lw/I-ALU 00, sw 01, beq 10, jal 11, others 00.

## Timing
- State register resets asynchronously to FETCH. `illegal` clears to 0.
- While `rst_n`=0, `mem_req`, `IRWrite`, `PCWrite`, `RegWrite` and `MemWrite` are forced to 0. All other outputs take their FETCH values.
- Reset release: the first `mem_req` appears in the first cycle with `rst_n`=1.
- Outputs are Moore, except:
  - `IRWrite`/`PCWrite` in FETCH are qualified by `mem_ready`;
  - `PCWrite` in BEQ is qualified by `zero`.
- Cycles per instruction with `mem_ready` held high: lw 5, sw 4, R 4, I 4, beq 3, jal 4. Each cycle of `mem_ready`=0 in FETCH, MEMREAD or MEMWRITE adds one cycle.
- Handshake: `mem_req` and `AdrSrc`/`MemWrite` stay stable until the cycle where `mem_ready`=1. The access completes in that cycle.
- Reset mid-access (e.g. in MEMWRITE) drops `mem_req`/`MemWrite` immediately, asynchronously. No `RegWrite` or `PCWrite` pulse may follow.

## Test plan
1. lw (op 0000011), `mem_ready`=1 → states 0,1,2,3,4,0; `RegWrite`=1 only in state 4 with `ResultSrc`=01; `ImmSrc`=00.
2. sw, `mem_ready` low for 3 cycles in MEMWRITE → `mem_req`=`MemWrite`=1 and `AdrSrc`=1 for 4 cycles, then FETCH; `RegWrite` never asserts; `ImmSrc`=01.
3. beq with `zero`=1, then with `zero`=0 → `PCWrite`=1 / 0 in state 9; `ALUControl`=001; `ImmSrc`=10; 3 cycles each.
4. R-type funct3=000, `funct7b5`=1 → `ALUControl`=001. I-type same fields → 000. funct3=111 → 010.
5. jal → states 0,1,10,8,0; `PCWrite`=1 in state 10; `RegWrite`=1 in state 8; `ImmSrc`=11.
6. op 1111111 → ILLEGAL (state 11), `illegal`=1 held for 10+ cycles. Reset asserted in MEMWRITE → `mem_req`=0 same cycle; after release, state=0 and `illegal`=0.
